datapath_regs: RTL
==================

DATAPATH_REGS -- requirements
Module: datapath_regs

Interface
REQ-001 Parameter DATA_W, default 8, shall set the register, bus and memory data width.
REQ-002 Parameter NREG, default 14, shall set the register count; it matches the width of WRT_en, INC_en and RST_en.
REQ-003 clk  in  1  shall be the single system clock (the divided clock); all state updates on the rising edge.
REQ-004 rst  in  1  shall be a synchronous, active-high reset.
REQ-005 ALU_OP  in  3  shall carry the ALU operation code from the control unit.
REQ-006 Bus_Select  in  4  shall select the bus source.
REQ-007 WRT_en / INC_en / RST_en  in  NREG each  shall be the per-register load, increment and clear strobes.
REQ-008 MEMCtrl  in  1  shall be the data-memory write strobe.
REQ-009 ir_in  in  DATA_W  shall carry the instruction register value, used as a bus source.
REQ-010 mem_rdata  in  DATA_W  shall carry data-RAM read data, valid one clk after mem_addr.
REQ-011 mem_addr, mem_wdata  out  DATA_W  and mem_wren  out  1  shall be the data-RAM port.
REQ-012 Z1, Z2  out  1  shall be the zero flags returned to the control unit.
REQ-013 bus_out, ac_out  out  DATA_W  shall expose the current bus value and the AC value.

Function
REQ-014 The bus shall be combinational: reg[Bus_Select] for 0..NREG-1, ir_in for 14, and 0 for 15.
REQ-015 Per-register priority each edge shall be: RST_en clears to 0, else WRT_en loads the bus, else INC_en adds 1 modulo 2^DATA_W (FF->00), else hold.
REQ-016 A register loading a bus driven by itself shall capture its pre-edge value, with no combinational loop.
REQ-017 For index DR, a WRT_en load with MEMCtrl=0 shall take mem_rdata instead of the bus.
REQ-018 mem_addr shall equal reg[AR] continuously, mem_wdata shall equal bus_out, and mem_wren shall equal MEMCtrl, unregistered.
REQ-019 AC ALU ops shall be: 000 hold, 001 AC+bus, 010 AC-bus, 011 bus, 100 clear, 101 AC+1, 110 AC-1, 111 hold.
REQ-020 ALU results shall be truncated to DATA_W with no carry out.
REQ-021 AC priority shall be: RST_en[AC] > non-hold ALU_OP > WRT_en[AC] > INC_en[AC].
REQ-022 Z1 shall be registered and updated only on a non-hold ALU op, set to (new AC == 0); otherwise it holds.
REQ-023 The zero test for Z1 shall use the truncated result, so 01-01 and FF+1 both set Z1.
REQ-024 The ALU shall be a sequential two-state controller, IDLE -> EXEC on a non-hold op.
REQ-025 In EXEC, AC and Z1 commit that edge and the controller returns to IDLE the next cycle; a back-to-back op shall stay in EXEC.

Reset
REQ-026 rst shall clear all registers, AC, Z1 and Z2 to 0 and force ALU state IDLE, taking priority over every strobe in the same cycle.
REQ-027 rst asserted mid-operation (EXEC) shall discard the pending result; no partial update survives.

Configuration
REQ-028 With DP_Z2_EN defined, Z2 shall be registered, set each edge to (next reg[LC] == 0), where LC is the loop-counter index.
REQ-029 Without DP_Z2_EN, Z2 shall be tied to 0 and no Z2 logic is generated.

Structure
REQ-030 Register index constants (AR, DR, AC, LC and the others up to 13), the bus-select codes and the ALU_OP codes shall live in define.v.
REQ-031 The ALU shall be one sub-module, dp_alu, holding the op decode, arithmetic and zero detect; the register array stays in datapath_regs.

Verification
REQ-032 Scenario: rst=1 with all WRT_en set -> all registers, Z1 and Z2 read 0 next cycle.
REQ-033 Scenario: Bus_Select=14, ir_in=8'h5A, WRT_en[AR]=1 -> reg[AR]=5A and mem_addr=5A.
REQ-034 Scenario: reg[LC]=FF with INC_en[LC]=1 -> 00 (wrap); with DP_Z2_EN, Z2=1 on the same edge.
REQ-035 Scenario: AC=03, bus=03, ALU_OP=010 -> AC=00 and Z1=1; then ALU_OP=000 -> Z1 stays 1.
REQ-036 Scenario: RST_en[AC]=1 with ALU_OP=001 and WRT_en[AC]=1 -> AC=00.
REQ-037 Scenario: reg[AR]=10, mem_rdata=C3 one cycle later, WRT_en[DR]=1, MEMCtrl=0 -> DR=C3; MEMCtrl=1 -> mem_wren=1 with mem_wdata=bus_out.

Source files
------------

// File: rtl/datapath_regs_pkg.sv
// datapath_regs_pkg: register indices, bus-select codes, ALU op codes and ALU controller states
package datapath_regs_pkg;
  localparam int AR  = 0;
  localparam int DR  = 1;
  localparam int AC  = 2;
  localparam int LC  = 3;
  localparam int PC  = 4;
  localparam int TR  = 5;
  localparam int SP  = 6;
  localparam int IX  = 7;
  localparam int R8  = 8;
  localparam int R9  = 9;
  localparam int R10 = 10;
  localparam int R11 = 11;
  localparam int R12 = 12;
  localparam int R13 = 13;
  localparam logic [3:0] BUS_IR   = 4'd14;
  localparam logic [3:0] BUS_ZERO = 4'd15;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_LDB  = 3'd3,
    OP_CLR  = 3'd4,
    OP_INC  = 3'd5,
    OP_DEC  = 3'd6,
    OP_HOLD = 3'd7
  } alu_op_e;
  typedef enum logic {ST_IDLE, ST_EXEC} alu_state_e;
  function automatic logic is_exec(input logic [2:0] op);
    return op != OP_NOP && op != OP_HOLD;
  endfunction
endpackage

// File: rtl/datapath_regs_alu.sv
// dp_alu: AC op decode, truncated arithmetic, IDLE/EXEC controller and registered zero flag Z1
module dp_alu
  import datapath_regs_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_ac,
  input  logic [DATA_W-1:0] i_bus,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_res,
  output logic              o_we,
  output logic              o_z1
);
  alu_state_e r_state;
  logic       r_z1;
  // Decode the op into a DATA_W-truncated result and a commit strobe
  always_comb begin
    o_we  = is_exec(i_op);
    o_res = i_op == OP_ADD ? i_ac + i_bus :
            i_op == OP_SUB ? i_ac - i_bus :
            i_op == OP_LDB ? i_bus :
            i_op == OP_CLR ? '0 :
            i_op == OP_INC ? i_ac + DATA_W'(1) :
            i_op == OP_DEC ? i_ac - DATA_W'(1) : i_ac;
  end
  // Controller stays in EXEC while ops arrive back to back; Z1 tracks the AC value actually committed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_z1    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= o_we ? ST_EXEC : ST_IDLE;
        ST_EXEC: r_state <= o_we ? ST_EXEC : ST_IDLE;
      endcase
      if (o_we) r_z1 <= i_clr || o_res == '0;
    end
  end
  assign o_z1 = r_z1;
endmodule

// File: rtl/datapath_regs.sv
// datapath_regs: register file, shared bus, AC/ALU and data-RAM port; define DP_Z2_EN to build the LC zero flag Z2
module datapath_regs
  import datapath_regs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        ALU_OP,
  input  logic [3:0]        Bus_Select,
  input  logic [NREG-1:0]   WRT_en,
  input  logic [NREG-1:0]   INC_en,
  input  logic [NREG-1:0]   RST_en,
  input  logic              MEMCtrl,
  input  logic [DATA_W-1:0] ir_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              Z1,
  output logic              Z2,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] ac_out
);
  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] w_next [NREG];
  logic [DATA_W-1:0] w_bus;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_we;
  assign w_bus     = Bus_Select < 4'(NREG) ? r_regs[Bus_Select] : Bus_Select == BUS_IR ? ir_in : '0;
  assign bus_out   = w_bus;
  assign ac_out    = r_regs[AC];
  assign mem_addr  = r_regs[AR];
  assign mem_wdata = w_bus;
  assign mem_wren  = MEMCtrl;
  dp_alu #(.DATA_W(DATA_W)) u_alu (
    .clk   (clk),
    .rst   (rst),
    .i_op  (ALU_OP),
    .i_ac  (r_regs[AC]),
    .i_bus (w_bus),
    .i_clr (RST_en[AC]),
    .o_res (w_alu_res),
    .o_we  (w_alu_we),
    .o_z1  (Z1)
  );
  // Next value per register: clear > load > increment > hold; DR loads memory on reads, AC lets the ALU outrank a load
  always_comb begin
    for (int i = 0; i < NREG; i++)
      w_next[i] = RST_en[i] ? '0 :
                  WRT_en[i] ? ((i == DR && !MEMCtrl) ? mem_rdata : w_bus) :
                  INC_en[i] ? r_regs[i] + DATA_W'(1) : r_regs[i];
    w_next[AC] = RST_en[AC] ? '0 :
                 w_alu_we   ? w_alu_res :
                 WRT_en[AC] ? w_bus :
                 INC_en[AC] ? r_regs[AC] + DATA_W'(1) : r_regs[AC];
  end
  // Register array commit; the bus is sampled pre-edge so self-loads are loop free
  always_ff @(posedge clk)
    for (int i = 0; i < NREG; i++) r_regs[i] <= rst ? '0 : w_next[i];
`ifdef DP_Z2_EN
  logic r_z2;
  // Z2 flags the loop counter reaching zero on the same edge it is written
  always_ff @(posedge clk) r_z2 <= rst ? 1'b0 : w_next[LC] == '0;
  assign Z2 = r_z2;
`else
  assign Z2 = 1'b0;
`endif
endmodule
